strip_conv_scheduler: RTL and testbench

STRIP_CONV_SCHEDULER -- requirements
Module: strip_conv_scheduler

---
 rtl/strip_conv_scheduler.sv | 157 +++++++++++++++
 tb/tb_strip_conv_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/strip_conv_scheduler.sv
// Purpose: sequences one frame: reset strip units, launch them, wait for done, then drain each strip BRAM in order.
// Latency: out_valid follows each strip_addr by READ_LATENCY cycles; frame_done lands in the cycle of the last word.
// Backpressure: none; the consumer takes every out_valid word. Define STRIP_PARALLEL_EN to run all four units at once.
module strip_conv_scheduler #(
    parameter int STRIP_WORDS  = 6216,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        kernel_read_complete,
    input  logic [3:0]  unit_done,
    input  logic [91:0] strip_dout,
    output logic        unit_reset,
    output logic [3:0]  unit_start,
    output logic [12:0] strip_addr,
    output logic        out_valid,
    output logic [22:0] out_data,
    output logic [1:0]  out_strip,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LAUNCH, S_WAIT_DONE, S_DRAIN, S_FLUSH, S_FINISH
    } state_t;

    localparam logic [12:0] LAST_ADDR    = 13'(STRIP_WORDS - 1);
    // FLUSH + FINISH cover the in-flight reads so frame_done coincides with the last word.
    localparam int          FLUSH_CYCLES = (READ_LATENCY > 2) ? READ_LATENCY - 1 : 1;
    localparam logic [7:0]  FLUSH_LAST   = 8'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [12:0] addr_q, addr_d;
    logic [1:0]  strip_q, strip_d;
    logic [7:0]  flush_q, flush_d;
    logic        vld_pipe_q   [READ_LATENCY];
    logic        vld_pipe_d   [READ_LATENCY];
    logic [1:0]  strip_pipe_q [READ_LATENCY];
    logic [1:0]  strip_pipe_d [READ_LATENCY];
    logic [1:0]  sel_strip;
    logic [22:0] sel_slice;
`ifndef STRIP_PARALLEL_EN
    logic [1:0]  k_q, k_d;
`endif

    // State register; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers; reset also empties the read pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            strip_q <= '0;
            flush_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_pipe_q[i]   <= 1'b0;
                strip_pipe_q[i] <= 2'd0;
            end
`ifndef STRIP_PARALLEL_EN
            k_q <= '0;
`endif
        end else begin
            addr_q  <= addr_d;
            strip_q <= strip_d;
            flush_q <= flush_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_pipe_q[i]   <= vld_pipe_d[i];
                strip_pipe_q[i] <= strip_pipe_d[i];
            end
`ifndef STRIP_PARALLEL_EN
            k_q <= k_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (frame_start && kernel_read_complete) state_d = S_CLR;
            S_CLR:       state_d = S_LAUNCH;
            S_LAUNCH:    state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
`ifdef STRIP_PARALLEL_EN
                if (unit_done == 4'b1111) state_d = S_DRAIN;
`else
                if (unit_done[k_q]) state_d = (k_q == 2'd3) ? S_DRAIN : S_LAUNCH;
`endif
            end
            S_DRAIN:     if (addr_q == LAST_ADDR && strip_q == 2'd3) state_d = S_FLUSH;
            S_FLUSH:     if (flush_q == FLUSH_LAST) state_d = S_FINISH;
            S_FINISH:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Address/strip counters, flush timer, unit index and read-pipeline shift.
    always_comb begin
        addr_d  = 13'd0;
        strip_d = 2'd0;
        flush_d = 8'd0;
        if (state_q == S_DRAIN) begin
            if (addr_q == LAST_ADDR) begin
                addr_d  = 13'd0;
                strip_d = strip_q + 2'd1;
            end else begin
                addr_d  = addr_q + 13'd1;
                strip_d = strip_q;
            end
        end
        if (state_q == S_FLUSH) flush_d = flush_q + 8'd1;
`ifndef STRIP_PARALLEL_EN
        k_d = k_q;
        if (state_q == S_CLR)
            k_d = 2'd0;
        else if (state_q == S_WAIT_DONE && unit_done[k_q] && k_q != 2'd3)
            k_d = k_q + 2'd1;
`endif
        vld_pipe_d[0]   = (state_q == S_DRAIN);
        strip_pipe_d[0] = strip_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe_d[i]   = vld_pipe_q[i-1];
            strip_pipe_d[i] = strip_pipe_q[i-1];
        end
    end

    // Outputs decoded from state and the tail of the read pipeline.
    always_comb begin
        unit_reset = (state_q == S_CLR);
        unit_start = 4'b0000;
        if (state_q == S_LAUNCH) begin
`ifdef STRIP_PARALLEL_EN
            unit_start = 4'b1111;
`else
            unit_start = 4'b0001 << k_q;
`endif
        end
        strip_addr = (state_q == S_DRAIN) ? addr_q : 13'd0;
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_FINISH);
        out_valid  = vld_pipe_q[READ_LATENCY-1];
        sel_strip  = strip_pipe_q[READ_LATENCY-1];
        case (sel_strip)
            2'd0:    sel_slice = strip_dout[22:0];
            2'd1:    sel_slice = strip_dout[45:23];
            2'd2:    sel_slice = strip_dout[68:46];
            default: sel_slice = strip_dout[91:69];
        endcase
        out_strip = out_valid ? sel_strip : 2'd0;
        out_data  = out_valid ? sel_slice : 23'd0;
    end

endmodule

// File: tb/tb_strip_conv_scheduler.sv
// Purpose: directed self-checking bench for strip_conv_scheduler with STRIP_WORDS=4, READ_LATENCY=2.
// Latency: inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Backpressure: none; every out_valid word is counted and compared as it appears.
module tb_strip_conv_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        kernel_read_complete;
    logic [3:0]  unit_done;
    logic [91:0] strip_dout;
    logic        unit_reset;
    logic [3:0]  unit_start;
    logic [12:0] strip_addr;
    logic        out_valid;
    logic [22:0] out_data;
    logic [1:0]  out_strip;
    logic        busy;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int words;
    int dones;

`ifdef STRIP_PARALLEL_EN
    localparam int TO_DRAIN = 3;
`else
    localparam int TO_DRAIN = 9;
`endif

    strip_conv_scheduler #(.STRIP_WORDS(4), .READ_LATENCY(2)) dut (
        .clk                  (clk),
        .reset                (reset),
        .frame_start          (frame_start),
        .kernel_read_complete (kernel_read_complete),
        .unit_done            (unit_done),
        .strip_dout           (strip_dout),
        .unit_reset           (unit_reset),
        .unit_start           (unit_start),
        .strip_addr           (strip_addr),
        .out_valid            (out_valid),
        .out_data             (out_data),
        .out_strip            (out_strip),
        .busy                 (busy),
        .frame_done           (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_unit_reset"}, unit_reset, 0);
        chk({tag, "_unit_start"}, unit_start, 0);
        chk({tag, "_strip_addr"}, strip_addr, 0);
        chk({tag, "_out_valid"},  out_valid,  0);
        chk({tag, "_out_data"},   out_data,   0);
        chk({tag, "_out_strip"},  out_strip,  0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        reset                = 1'b1;
        frame_start          = 1'b0;
        kernel_read_complete = 1'b0;
        unit_done            = 4'b0000;
        strip_dout           = {23'd103, 23'd102, 23'd101, 23'd100};
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b0;

        // Request without kernels loaded must be ignored.
        frame_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("nokernel_busy",  busy,       0);
            chk("nokernel_start", unit_start, 0);
        end
        frame_start = 1'b0;

        // Frame 1: clear, launch, wait with a stray frame_start, then drain.
        frame_start          = 1'b1;
        kernel_read_complete = 1'b1;
        step();
        chk("clr_unit_reset", unit_reset, 1);
        chk("clr_busy",       busy,       1);
        chk("clr_unit_start", unit_start, 0);
        frame_start = 1'b0;
        step();
        chk("launch_unit_reset", unit_reset, 0);
`ifdef STRIP_PARALLEL_EN
        chk("launch_all", unit_start, 4'hF);
        step();
        chk("wait1_start", unit_start, 0);
        frame_start = 1'b1;
        step();
        chk("wait2_start", unit_start, 0);
        chk("wait2_reset", unit_reset, 0);
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("waitn_start", unit_start, 0);
            chk("waitn_busy",  busy,       1);
        end
        unit_done = 4'hF;
        step();
`else
        chk("launch_u0", unit_start, 4'b0001);
        step();
        chk("wait_u0_a", unit_start, 0);
        frame_start = 1'b1;
        step();
        chk("wait_u0_b", unit_start, 0);
        chk("wait_u0_rst", unit_reset, 0);
        frame_start = 1'b0;
        unit_done   = 4'b0001;
        step();
        chk("launch_u1", unit_start, 4'b0010);
        step();
        chk("wait_u1", unit_start, 0);
        unit_done = 4'b0011;
        step();
        chk("launch_u2", unit_start, 4'b0100);
        unit_done = 4'b0111;
        step();
        chk("wait_u2", unit_start, 0);
        chk("wait_u2_busy", busy, 1);
        step();
        chk("launch_u3", unit_start, 4'b1000);
        step();
        chk("wait_u3", unit_start, 0);
        unit_done = 4'b1111;
        step();
`endif
        unit_done = 4'b0000;
        kernel_read_complete = 1'b0;

        // DRAIN starts here; last address issues at c=15, last word and frame_done at c=17.
        words = 0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            chk("drain_addr",  strip_addr, (c < 16) ? (c % 4) : 0);
            chk("drain_valid", out_valid,  (c >= 2 && c < 18) ? 1 : 0);
            chk("drain_busy",  busy,       (c <= 17) ? 1 : 0);
            chk("drain_done",  frame_done, (c == 17) ? 1 : 0);
            chk("drain_start", unit_start, 0);
            if (c >= 2 && c < 18) begin
                chk("drain_strip", out_strip, (c - 2) / 4);
                chk("drain_data",  out_data,  100 + (c - 2) / 4);
            end else begin
                chk("drain_data_idle", out_data, 0);
            end
            if (out_valid)  words++;
            if (frame_done) dones++;
            step();
        end
        chk("frame_words", words, 16);
        chk("frame_dones", dones, 1);

        // Frame 2: reset during the third DRAIN cycle.
        frame_start          = 1'b1;
        kernel_read_complete = 1'b1;
        step();
        chk("f2_clr", unit_reset, 1);
        frame_start = 1'b0;
        unit_done   = 4'hF;
        for (int i = 0; i < TO_DRAIN; i++) step();
        chk("f2_d0_addr",  strip_addr, 0);
        chk("f2_d0_valid", out_valid,  0);
        step();
        chk("f2_d1_addr",  strip_addr, 1);
        step();
        chk("f2_d2_addr",  strip_addr, 2);
        chk("f2_d2_valid", out_valid,  1);
        reset = 1'b1;
        step();
        chk_reset_vals("midrst");
        // A request held together with reset must lose to reset.
        frame_start = 1'b1;
        step();
        chk("rst_prio_busy", busy, 0);
        reset                = 1'b0;
        frame_start          = 1'b0;
        kernel_read_complete = 1'b0;
        unit_done            = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_busy",  busy,      0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
